// File: rtl/skew_row_buffer.sv
// Multi-bank ping-pong skewing row buffer: rows are stored diagonally (lane j of
// row r in line r+j) and streamed out line by line, zeroing each line as it leaves.
module skew_row_buffer #(
  parameter int INPUT_WIDTH   = 8,
  parameter int MATRIX_SIZE   = 3,
  parameter int ROWS_PER_TILE = MATRIX_SIZE,
  parameter int NUM_BANKS     = 2,
  parameter int BANK_DEPTH    = ROWS_PER_TILE + MATRIX_SIZE - 1,
  parameter int BANK_SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [BANK_SEL_W-1:0]              wr_bank,
  input  logic [MATRIX_SIZE*INPUT_WIDTH-1:0] wr_data,
  input  logic                               rd_start,
  input  logic [BANK_SEL_W-1:0]              rd_bank,
  output logic                               rd_valid,
  output logic [MATRIX_SIZE*INPUT_WIDTH-1:0] rd_data,
  output logic                               rd_last,
  output logic                               rd_busy,
  output logic                               rd_err,
  output logic [NUM_BANKS-1:0]               bank_full,
  output logic [NUM_BANKS-1:0]               bank_empty
);

  localparam int DATA_W = MATRIX_SIZE * INPUT_WIDTH;
  localparam int ROW_W  = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam int LINE_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_t;

  logic [DATA_W-1:0]     mem_r     [NUM_BANKS][BANK_DEPTH];
  bank_state_t           state_r   [NUM_BANKS];
  logic [ROW_W-1:0]      row_cnt_r [NUM_BANKS];
  logic [LINE_W-1:0]     line_cnt_r;
  logic [BANK_SEL_W-1:0] rd_bank_r;
  logic                  rd_valid_r;
  logic [DATA_W-1:0]     rd_data_r;
  logic                  rd_last_r;
  logic                  rd_busy_r;
  logic                  rd_err_r;

  logic                  wr_ready_s;
  logic                  wr_fire_s;
  logic                  rd_full_s;
  logic                  rd_accept_s;
  logic                  rd_take_s;
  logic [BANK_SEL_W-1:0] rd_src_s;
  logic [LINE_W-1:0]     rd_idx_s;
  logic [DATA_W-1:0]     rd_line_s;

  // Bank selection, read acceptance and the line to be emitted at the next edge.
  always_comb begin
    wr_ready_s = 1'b0;
    rd_full_s  = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_ready_s = wr_ready_s | ((wr_bank == BANK_SEL_W'(b)) &&
                   ((state_r[b] == ST_EMPTY) || (state_r[b] == ST_FILLING)));
      rd_full_s  = rd_full_s | ((rd_bank == BANK_SEL_W'(b)) && (state_r[b] == ST_FULL));
    end
    // A new tile may start in the final line cycle of the current one, so streams abut.
    rd_accept_s = rd_start && rd_full_s && (!rd_busy_r || rd_last_r);
    if (rd_accept_s) begin
      rd_take_s = 1'b1;
      rd_src_s  = rd_bank;
      rd_idx_s  = '0;
    end else if (rd_busy_r && !rd_last_r) begin
      rd_take_s = 1'b1;
      rd_src_s  = rd_bank_r;
      rd_idx_s  = line_cnt_r;
    end else begin
      rd_take_s = 1'b0;
      rd_src_s  = rd_bank_r;
      rd_idx_s  = line_cnt_r;
    end
    rd_line_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < BANK_DEPTH; l++) begin
        rd_line_s = rd_line_s | ({DATA_W{rd_take_s && (rd_src_s == BANK_SEL_W'(b)) &&
                                         (rd_idx_s == LINE_W'(l))}} & mem_r[b][l]);
      end
    end
  end

  assign wr_fire_s = wr_valid && wr_ready_s;
  assign wr_ready  = wr_ready_s;

  // Line storage: diagonal lane writes, and zero-on-read of the line being streamed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int l = 0; l < BANK_DEPTH; l++) begin
          mem_r[b][l] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int l = 0; l < BANK_DEPTH; l++) begin
          if (rd_take_s && (rd_src_s == BANK_SEL_W'(b)) && (rd_idx_s == LINE_W'(l))) begin
            mem_r[b][l] <= '0;
          end else begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
              if (wr_fire_s && (wr_bank == BANK_SEL_W'(b)) &&
                  (int'(row_cnt_r[b]) + j == l)) begin
                mem_r[b][l][(MATRIX_SIZE-j)*INPUT_WIDTH-1 -: INPUT_WIDTH] <=
                  wr_data[(MATRIX_SIZE-j)*INPUT_WIDTH-1 -: INPUT_WIDTH];
              end
            end
          end
        end
      end
    end
  end

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_r[b]   <= ST_EMPTY;
        row_cnt_r[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        case (state_r[b])
          ST_EMPTY, ST_FILLING: begin
            if (wr_fire_s && (wr_bank == BANK_SEL_W'(b))) begin
              if (row_cnt_r[b] == ROW_W'(ROWS_PER_TILE - 1)) begin
                state_r[b]   <= ST_FULL;
                row_cnt_r[b] <= '0;
              end else begin
                state_r[b]   <= ST_FILLING;
                row_cnt_r[b] <= row_cnt_r[b] + ROW_W'(1);
              end
            end
          end
          ST_FULL: begin
            if (rd_accept_s && (rd_bank == BANK_SEL_W'(b))) begin
              state_r[b] <= ST_DRAINING;
            end
          end
          ST_DRAINING: begin
            if (rd_last_r && (rd_bank_r == BANK_SEL_W'(b))) begin
              state_r[b] <= ST_EMPTY;
            end
          end
          default: begin
            state_r[b]   <= ST_EMPTY;
            row_cnt_r[b] <= '0;
          end
        endcase
      end
    end
  end

  // Registered read port; data is forced to zero whenever no line is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_r <= '0;
      rd_bank_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_last_r  <= 1'b0;
      rd_busy_r  <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      rd_err_r <= rd_start && !rd_accept_s;
      if (rd_take_s) begin
        line_cnt_r <= rd_idx_s + LINE_W'(1);
        rd_bank_r  <= rd_src_s;
        rd_valid_r <= 1'b1;
        rd_data_r  <= rd_line_s;
        rd_last_r  <= (rd_idx_s == LINE_W'(BANK_DEPTH - 1));
        rd_busy_r  <= 1'b1;
      end else begin
        rd_valid_r <= 1'b0;
        rd_data_r  <= '0;
        rd_last_r  <= 1'b0;
        rd_busy_r  <= 1'b0;
      end
    end
  end

  // Bank status flags decoded straight from the state registers.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_full[b]  = (state_r[b] == ST_FULL);
      bank_empty[b] = (state_r[b] == ST_EMPTY);
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_last  = rd_last_r;
  assign rd_busy  = rd_busy_r;
  assign rd_err   = rd_err_r;

endmodule

// File: tb/tb_skew_row_buffer.sv
// Directed, table-driven bench for skew_row_buffer with default parameters.
module tb_skew_row_buffer;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_bank;
  logic [23:0] wr_data;
  logic        rd_start;
  logic [0:0]  rd_bank;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_last;
  logic        rd_busy;
  logic        rd_err;
  logic [1:0]  bank_full;
  logic [1:0]  bank_empty;

  int n_checks = 0;
  int n_fail   = 0;

  skew_row_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_data(wr_data),
    .rd_start(rd_start), .rd_bank(rd_bank),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
    .rd_err(rd_err), .bank_full(bank_full), .bank_empty(bank_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic        wb;
    logic [23:0] wd;
    logic        rs;
    logic        rb;
    logic        e_ready;
    logic        e_valid;
    logic [23:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_err;
    logic [1:0]  e_full;
    logic [1:0]  e_empty;
  } vec_t;

  function automatic logic [23:0] r3(input int a, input int b, input int c);
    return {8'(a), 8'(b), 8'(c)};
  endfunction

  function automatic vec_t mk(input logic wv, input logic wb, input logic [23:0] wd,
                              input logic rs, input logic rb, input logic e_ready,
                              input logic e_valid, input logic [23:0] e_data,
                              input logic e_last, input logic e_busy, input logic e_err,
                              input logic [1:0] e_full, input logic [1:0] e_empty);
    vec_t v;
    v.wv = wv; v.wb = wb; v.wd = wd; v.rs = rs; v.rb = rb;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data; v.e_last = e_last;
    v.e_busy = e_busy; v.e_err = e_err; v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: drive inputs, check wr_ready before the edge, check registered outputs after.
  task automatic apply(input vec_t v, input string tag);
    wr_valid = v.wv; wr_bank = v.wb; wr_data = v.wd; rd_start = v.rs; rd_bank = v.rb;
    #1;
    check({tag, " wr_ready"}, 32'(wr_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    check({tag, " rd_valid"},   32'(rd_valid),   32'(v.e_valid));
    check({tag, " rd_data"},    32'(rd_data),    32'(v.e_data));
    check({tag, " rd_last"},    32'(rd_last),    32'(v.e_last));
    check({tag, " rd_busy"},    32'(rd_busy),    32'(v.e_busy));
    check({tag, " rd_err"},     32'(rd_err),     32'(v.e_err));
    check({tag, " bank_full"},  32'(bank_full),  32'(v.e_full));
    check({tag, " bank_empty"}, 32'(bank_empty), 32'(v.e_empty));
  endtask

  vec_t tbl [22];
  logic [23:0] r999;
  logic [23:0] r111;
  logic [23:0] r777;

  initial begin
    r999 = r3(9, 9, 9);
    r111 = r3(1, 1, 1);
    r777 = r3(7, 7, 7);
    // fill bank 0 with errors on EMPTY/FILLING/not-yet-FULL, backpressure, drain while
    // bank 1 fills, mid-stream reject, back-to-back bank 1, then reuse of bank 0
    tbl[0]  = mk(0, 0, 0,           1, 0, 1, 0, 0,          0, 0, 1, 2'b00, 2'b11);
    tbl[1]  = mk(1, 0, r3(1, 2, 3), 0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b10);
    tbl[2]  = mk(1, 0, r3(4, 5, 6), 1, 0, 1, 0, 0,          0, 0, 1, 2'b00, 2'b10);
    tbl[3]  = mk(1, 0, r3(7, 8, 9), 1, 0, 1, 0, 0,          0, 0, 1, 2'b01, 2'b10);
    tbl[4]  = mk(1, 0, r3(5, 5, 5), 0, 0, 0, 0, 0,          0, 0, 0, 2'b01, 2'b10);
    tbl[5]  = mk(1, 1, r999,        1, 0, 1, 1, r3(1, 0, 0), 0, 1, 0, 2'b00, 2'b00);
    tbl[6]  = mk(1, 1, r999,        1, 0, 1, 1, r3(4, 2, 0), 0, 1, 1, 2'b00, 2'b00);
    tbl[7]  = mk(1, 1, r999,        0, 0, 1, 1, r3(7, 5, 3), 0, 1, 0, 2'b10, 2'b00);
    tbl[8]  = mk(0, 1, 0,           1, 1, 0, 1, r3(0, 8, 6), 0, 1, 1, 2'b10, 2'b00);
    tbl[9]  = mk(0, 1, 0,           0, 0, 0, 1, r3(0, 0, 9), 1, 1, 0, 2'b10, 2'b00);
    tbl[10] = mk(0, 0, 0,           1, 1, 0, 1, r3(9, 0, 0), 0, 1, 0, 2'b00, 2'b01);
    tbl[11] = mk(1, 0, r111,        0, 0, 1, 1, r3(9, 9, 0), 0, 1, 0, 2'b00, 2'b00);
    tbl[12] = mk(1, 0, r111,        0, 0, 1, 1, r3(9, 9, 9), 0, 1, 0, 2'b00, 2'b00);
    tbl[13] = mk(1, 0, r111,        0, 0, 1, 1, r3(0, 9, 9), 0, 1, 0, 2'b01, 2'b00);
    tbl[14] = mk(0, 0, 0,           0, 0, 0, 1, r3(0, 0, 9), 1, 1, 0, 2'b01, 2'b00);
    tbl[15] = mk(0, 0, 0,           0, 0, 0, 0, 0,          0, 0, 0, 2'b01, 2'b10);
    tbl[16] = mk(0, 0, 0,           1, 0, 0, 1, r3(1, 0, 0), 0, 1, 0, 2'b00, 2'b10);
    tbl[17] = mk(0, 0, 0,           0, 0, 0, 1, r3(1, 1, 0), 0, 1, 0, 2'b00, 2'b10);
    tbl[18] = mk(0, 0, 0,           0, 0, 0, 1, r3(1, 1, 1), 0, 1, 0, 2'b00, 2'b10);
    tbl[19] = mk(0, 0, 0,           0, 0, 0, 1, r3(0, 1, 1), 0, 1, 0, 2'b00, 2'b10);
    tbl[20] = mk(0, 0, 0,           0, 0, 0, 1, r3(0, 0, 1), 1, 1, 0, 2'b00, 2'b10);
    tbl[21] = mk(0, 0, 0,           0, 0, 0, 0, 0,          0, 0, 0, 2'b00, 2'b11);

    reset_n = 1'b0;
    wr_valid = 1'b0; wr_bank = 1'b0; wr_data = '0; rd_start = 1'b0; rd_bank = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset wr_ready",   32'(wr_ready),   32'(1));
    check("reset rd_valid",   32'(rd_valid),   32'(0));
    check("reset rd_data",    32'(rd_data),    32'(0));
    check("reset rd_last",    32'(rd_last),    32'(0));
    check("reset rd_busy",    32'(rd_busy),    32'(0));
    check("reset rd_err",     32'(rd_err),     32'(0));
    check("reset bank_full",  32'(bank_full),  32'(0));
    check("reset bank_empty", 32'(bank_empty), 32'(3));

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of a bank 1 stream, after line 2 is presented
    apply(mk(1, 1, r777, 0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b01), "h0");
    apply(mk(1, 1, r777, 0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b01), "h1");
    apply(mk(1, 1, r777, 0, 0, 1, 0, 0,          0, 0, 0, 2'b10, 2'b01), "h2");
    apply(mk(0, 0, 0,    1, 1, 1, 1, r3(7, 0, 0), 0, 1, 0, 2'b00, 2'b01), "h3");
    apply(mk(0, 0, 0,    0, 0, 1, 1, r3(7, 7, 0), 0, 1, 0, 2'b00, 2'b01), "h4");
    apply(mk(0, 0, 0,    0, 0, 1, 1, r777,        0, 1, 0, 2'b00, 2'b01), "h5");
    wr_valid = 1'b0; rd_start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset rd_valid",   32'(rd_valid),   32'(0));
    check("midreset rd_data",    32'(rd_data),    32'(0));
    check("midreset rd_busy",    32'(rd_busy),    32'(0));
    check("midreset bank_full",  32'(bank_full),  32'(0));
    check("midreset bank_empty", 32'(bank_empty), 32'(3));
    @(negedge clk);
    reset_n = 1'b1;

    // Next tile into the same bank must carry no residue from the aborted one
    apply(mk(1, 1, r3(3, 1, 4), 0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b01), "g0");
    apply(mk(1, 1, r3(1, 5, 9), 0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b01), "g1");
    apply(mk(1, 1, r3(2, 6, 5), 0, 0, 1, 0, 0,          0, 0, 0, 2'b10, 2'b01), "g2");
    apply(mk(0, 0, 0,           1, 1, 1, 1, r3(3, 0, 0), 0, 1, 0, 2'b00, 2'b01), "g3");
    apply(mk(0, 0, 0,           0, 0, 1, 1, r3(1, 1, 0), 0, 1, 0, 2'b00, 2'b01), "g4");
    apply(mk(0, 0, 0,           0, 0, 1, 1, r3(2, 5, 4), 0, 1, 0, 2'b00, 2'b01), "g5");
    apply(mk(0, 0, 0,           0, 0, 1, 1, r3(0, 6, 9), 0, 1, 0, 2'b00, 2'b01), "g6");
    apply(mk(0, 0, 0,           0, 0, 1, 1, r3(0, 0, 5), 1, 1, 0, 2'b00, 2'b01), "g7");
    apply(mk(0, 0, 0,           0, 0, 1, 0, 0,          0, 0, 0, 2'b00, 2'b11), "g8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_row_buffer.md
# skew_row_buffer

Multi-bank, ping-pong skewing row buffer that sits between the softmax / row producer and the systolic array input edge. Each accepted input row is stored diagonally (lane j of row r lands in line r+j) so that streaming the lines out in order presents the staggered wavefront the array expects. Generalises the single-region Q/S buffer to NUM_BANKS independent banks with valid/ready write, whole-tile streaming read, and automatic zero-on-read clearing.

## Interface
- INPUT_WIDTH, 8, bits per lane element (signed data, treated as opaque)
- MATRIX_SIZE, 3, lanes per row = array edge length
- ROWS_PER_TILE, MATRIX_SIZE, rows written per tile before a bank is full
- NUM_BANKS, 2, independent banks (≥2)
- BANK_DEPTH, ROWS_PER_TILE+MATRIX_SIZE-1, skewed lines per bank (derived, do not override)
- BANK_SEL_W, max(1,$clog2(NUM_BANKS)), bank index width (derived)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write row offered
- wr_ready  out  1  target bank (wr_bank) can accept a row
- wr_bank  in  BANK_SEL_W  target bank for write
- wr_data  in  MATRIX_SIZE*INPUT_WIDTH  row; lane j at bits [(MATRIX_SIZE-j)*INPUT_WIDTH-1 -: INPUT_WIDTH] (lane 0 in MSBs)
- rd_start  in  1  one-cycle request to stream bank rd_bank
- rd_bank  in  BANK_SEL_W  bank to stream
- rd_valid  out  1  rd_data carries a skewed line
- rd_data  out  MATRIX_SIZE*INPUT_WIDTH  skewed line, same lane packing
- rd_last  out  1  final line of the tile (with rd_valid)
- rd_busy  out  1  stream in progress
- rd_err  out  1  one-cycle pulse: rd_start rejected
- bank_full  out  NUM_BANKS  per-bank tile complete, awaiting read
- bank_empty  out  NUM_BANKS  per-bank no rows written

## Operation
- Per-bank state: EMPTY -> FILLING (first write) -> FULL (ROWS_PER_TILE-th write) -> DRAINING (accepted rd_start) -> EMPTY (after last line). Per-bank row counter 0..ROWS_PER_TILE-1.
- wr_ready = state[wr_bank] ∈ {EMPTY, FILLING}. Write fires on wr_valid && wr_ready: lane j of wr_data -> bank line (row_cnt+j), lane j; other lanes of those lines untouched. wr_bank ≥ NUM_BANKS: wr_ready=0.
- rd_start accepted iff state[rd_bank]==FULL and (not rd_busy, or rd_last is high this cycle). Otherwise ignored and rd_err pulses next cycle; no state change.
- DRAINING: line counter 0..BANK_DEPTH-1, one line per cycle, no backpressure. Each line is read and zeroed in the same cycle, so the bank returns to EMPTY already cleared.
- Write to a DRAINING or FULL bank blocked by wr_ready=0; write to one bank while another drains proceeds normally (ping-pong).
- rd_data is 0 whenever rd_valid=0.

## Timing
- Reset (async assert, sync release): all lines 0, all banks EMPTY, counters 0; wr_ready per wr_bank (1 after reset), rd_valid=0, rd_data=0, rd_last=0, rd_busy=0, rd_err=0, bank_full=0, bank_empty=all 1s. Reset mid-stream aborts the stream and discards all banks.
- Write: accepted at edge t; bank_empty drops, and on the final row bank_full rises, at t+1; wr_ready for that bank low from t+1.
- Read: rd_start at edge t -> line k on rd_data with rd_valid at t+1+k, k=0..BANK_DEPTH-1; rd_last at t+BANK_DEPTH; rd_busy high t+1..t+BANK_DEPTH; bank_full falls at t+1; bank_empty rises at t+BANK_DEPTH+1.
- Back-to-back: rd_start for another FULL bank in the rd_last cycle -> its line 0 follows with no bubble.
- Same bank: rd_start in same cycle the final write is accepted is rejected (bank not yet FULL) -> rd_err.

## Test plan
- MATRIX_SIZE=3, write rows {1,2,3},{4,5,6},{7,8,9} to bank 0, rd_start -> lines {1,0,0},{4,2,0},{7,5,3},{0,8,6},{0,0,9}, rd_last on 5th, bank_empty[0]=1 after.
- Ping-pong: fill bank 1 with {9,9,9}×3 while bank 0 drains; rd_start bank 1 in bank 0's rd_last cycle -> 10 contiguous rd_valid cycles, bank 1 lines {9,0,0},{9,9,0},{9,9,9},{0,9,9},{0,0,9}.
- Backpressure: wr_valid to FULL bank 0 -> wr_ready=0, contents unchanged on later read.
- Errors: rd_start on EMPTY bank, on FILLING bank, and during an active stream (not last cycle) -> rd_err pulse each, stream unaffected.
- Reuse: after drain, write {1,1,1}×3 to bank 0 -> output shows no residue from previous tile.
- Reset asserted at stream line 2 -> rd_valid=0 immediately, bank_empty all 1s, next tile reads correctly.
